// File: rtl/mul_sched.sv
// Round-robin scheduler that lends one shared sequential multiplier to four requesters.
// One operation: grant in IDLE, 8 RUN cycles of multiplier traffic, one ACK cycle with the product.
module mul_sched (
   input  logic         clock,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [127:0] opA,
   input  logic [127:0] opB,
   output logic [3:0]   ack,
   output logic [31:0]  prodLo,
   output logic [31:0]  prodHi,
   output logic         busy,
   output logic         err,
   output logic         selMul,
   output logic [31:0]  mulWq,
   input  logic         mulRwq,
   input  logic [31:0]  mulRq,
   input  logic         mulWrq,
   input  logic         mulDone
);

   typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

   // RUN cycle count at which a missing mulDone is declared a hang
   localparam logic [4:0] WD_LAST = 5'd19;

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  owner_q, owner_d;
   logic        phase_q, phase_d;
   logic [1:0]  wr_cnt_q, wr_cnt_d;
   logic [4:0]  wd_q, wd_d;
   logic        err_q, err_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic [1:0]  grant;

   // first requester at or above ptr, wrapping 3 -> 0
   always_comb begin
      grant = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req[ptr_q + 2'(k)]) begin
            grant = ptr_q + 2'(k);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         owner_q  <= 2'd0;
         phase_q  <= 1'b0;
         wr_cnt_q <= 2'd0;
         wd_q     <= 5'd0;
         err_q    <= 1'b0;
         lo_q     <= 32'd0;
         hi_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         phase_q  <= phase_d;
         wr_cnt_q <= wr_cnt_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      phase_d  = phase_q;
      wr_cnt_d = wr_cnt_q;
      wd_d     = wd_q;
      err_d    = err_q;
      lo_d     = lo_q;
      hi_d     = hi_q;

      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d  = grant;
               phase_d  = 1'b0;
               wr_cnt_d = 2'd0;
               wd_d     = 5'd0;
               lo_d     = 32'd0;
               hi_d     = 32'd0;
               state_d  = RUN;
            end
         end

         RUN: begin
            wd_d = wd_q + 5'd1;
            if (mulRwq) begin
               phase_d = 1'b1;
            end
            if (mulWrq) begin
               if (wr_cnt_q == 2'd0) begin
                  lo_d = mulRq;
               end else if (wr_cnt_q == 2'd1) begin
                  hi_d = mulRq;
               end
               if (wr_cnt_q != 2'd2) begin
                  wr_cnt_d = wr_cnt_q + 2'd1;
               end
            end
            if (mulDone) begin
               state_d = ACK;
            end else if (wd_q == WD_LAST) begin
               // timed out: still release the owner, but with a null product
               err_d   = 1'b1;
               lo_d    = 32'd0;
               hi_d    = 32'd0;
               state_d = ACK;
            end
         end

         ACK: begin
            ptr_d   = owner_q + 2'd1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      selMul = (state_q == RUN);
      err    = err_q;
      ack    = 4'd0;
      prodLo = 32'd0;
      prodHi = 32'd0;
      mulWq  = 32'd0;
      if (state_q == RUN) begin
         mulWq = phase_q ? opB[{owner_q, 5'd0} +: 32] : opA[{owner_q, 5'd0} +: 32];
      end
      if (state_q == ACK) begin
         ack    = 4'b0001 << owner_q;
         prodLo = lo_q;
         prodHi = hi_q;
      end
   end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: sequential multiplier model plus a queue of expected acks/products.
module tb_mul_sched;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req = 4'd0;
   logic [127:0] opA = '0;
   logic [127:0] opB = '0;
   logic [3:0]   ack;
   logic [31:0]  prodLo, prodHi;
   logic         busy, err, selMul;
   logic [31:0]  mulWq;
   logic         mulRwq, mulWrq, mulDone;
   logic [31:0]  mulRq;

   mul_sched dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .opA     (opA),
      .opB     (opB),
      .ack     (ack),
      .prodLo  (prodLo),
      .prodHi  (prodHi),
      .busy    (busy),
      .err     (err),
      .selMul  (selMul),
      .mulWq   (mulWq),
      .mulRwq  (mulRwq),
      .mulRq   (mulRq),
      .mulWrq  (mulWrq),
      .mulDone (mulDone)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] r;
      r = $signed(a) * $signed(b);
      return r;
   endfunction

   // multiplier model: operand words in counter steps 0,1; result words in 6,7
   int          m_cnt = 0;
   logic        m_hang = 1'b0;
   logic [31:0] m_a = 32'd0, m_b = 32'd0;
   logic [63:0] m_prod;
   logic [31:0] wq_log[$];
   int          sel_cnt = 0;

   assign mulRwq  = selMul && (m_cnt == 0 || m_cnt == 1);
   assign mulWrq  = selMul && (m_cnt == 6 || m_cnt == 7);
   assign mulDone = selMul && (m_cnt == 7) && !m_hang;
   assign m_prod  = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
   assign mulRq   = (m_cnt == 6) ? m_prod[31:0] : m_prod[63:32];

   always @(posedge clock) begin
      if (reset || !selMul) m_cnt <= 0;
      else                  m_cnt <= m_cnt + 1;
   end

   always @(negedge clock) begin
      if (selMul) sel_cnt++;
      if (selMul && mulRwq) begin
         if (m_cnt == 0) m_a = mulWq;
         else            m_b = mulWq;
         wq_log.push_back(mulWq);
      end
   end

   // scoreboard
   typedef struct packed {
      logic [3:0]  ack;
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;
   exp_t sb_q[$];

   always @(negedge clock) begin
      exp_t e;
      if (ack != 4'd0) begin
         if (sb_q.size() == 0) begin
            tb_check("unexpected_ack", 64'(ack), 64'd0);
         end else begin
            e = sb_q.pop_front();
            tb_check("ack_owner", 64'(ack), 64'(e.ack));
            tb_check("prodLo", 64'(prodLo), 64'(e.lo));
            tb_check("prodHi", 64'(prodHi), 64'(e.hi));
         end
      end else begin
         tb_check("prod_outside_ack", {prodHi, prodLo}, 64'd0);
      end
   end

   task automatic wait_ack(input int bound, output int c);
      bit got = 1'b0;
      c = -1;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clock);
         #1;
         if (ack != 4'd0) begin
            got = 1'b1;
            c = cyc;
         end
      end
      if (!got) tb_check("ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input int elat, input string tag);
      int   t0, c;
      exp_t e;
      @(negedge clock);
      opA[idx*32 +: 32] = a;
      opB[idx*32 +: 32] = b;
      e.ack = 4'b0001 << idx;
      e.lo  = elo;
      e.hi  = ehi;
      sb_q.push_back(e);
      wq_log.delete();
      sel_cnt = 0;
      req = 4'b0001 << idx;
      t0 = cyc;
      wait_ack(60, c);
      req = 4'd0;
      if (c >= 0) tb_check({tag, "_latency"}, 64'(c - t0), 64'(elat));
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          c, t0, tr;
      int          ack_c[5];
      logic [31:0] ta[4], tb[4];
      exp_t        e;

      repeat (2) @(negedge clock);
      tb_check("rst_busy", 64'(busy), 64'd0);
      tb_check("rst_ack", 64'(ack), 64'd0);
      tb_check("rst_selMul", 64'(selMul), 64'd0);
      tb_check("rst_mulWq", 64'(mulWq), 64'd0);
      tb_check("rst_err", 64'(err), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      tb_check("idle_selMul", 64'(selMul), 64'd0);

      // basic 7*6 on requester 0
      run_op(0, 32'd7, 32'd6, 32'd42, 32'd0, 9, "op7x6");
      tb_check("op7x6_wq_count", 64'(wq_log.size()), 64'd2);
      if (wq_log.size() == 2) begin
         tb_check("op7x6_wq0", 64'(wq_log[0]), 64'd7);
         tb_check("op7x6_wq1", 64'(wq_log[1]), 64'd6);
      end
      tb_check("op7x6_selMul_cycles", 64'(sel_cnt), 64'd8);

      run_op(1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 9, "neg1x3");
      run_op(0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000, 9, "minxmin");
      tb_check("err_before_wdog", 64'(err), 64'd0);

      // hung multiplier: timeout after 20 RUN cycles, null product, sticky err
      m_hang = 1'b1;
      run_op(0, 32'd5, 32'd9, 32'd0, 32'd0, 21, "wdog");
      tb_check("wdog_err", 64'(err), 64'd1);
      m_hang = 1'b0;
      run_op(3, 32'd11, 32'd13, 32'd143, 32'd0, 9, "post_wdog");
      tb_check("err_sticky", 64'(err), 64'd1);

      // reset in RUN cycle 4 of an op on requester 2
      @(negedge clock);
      opA[64 +: 32] = 32'd1000;
      opB[64 +: 32] = 32'hFFFF_FFFE;
      req = 4'b0100;
      t0 = cyc;
      repeat (4) @(negedge clock);
      tb_check("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      tb_check("abort_busy_after", 64'(busy), 64'd0);
      tb_check("abort_ack", 64'(ack), 64'd0);
      tb_check("abort_err_cleared", 64'(err), 64'd0);
      e.ack = 4'b0100;
      e.lo  = 32'hFFFF_F830;
      e.hi  = 32'hFFFF_FFFF;
      sb_q.push_back(e);
      reset = 1'b0;
      tr = cyc;
      wait_ack(60, c);
      req = 4'd0;
      if (c >= 0) tb_check("abort_retry_latency", 64'(c - tr), 64'd9);
      @(negedge clock);

      // all four requesting from reset: rotating service
      reset = 1'b1;
      ta[0] = 32'd3;          tb[0] = 32'd17;
      ta[1] = 32'hFFFF_FFFB;  tb[1] = 32'd100;
      ta[2] = 32'h0001_0000;  tb[2] = 32'h0001_0000;
      ta[3] = 32'h7FFF_FFFF;  tb[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         opA[i*32 +: 32] = ta[i];
         opB[i*32 +: 32] = tb[i];
      end
      for (int i = 0; i < 5; i++) begin
         e.ack = 4'b0001 << (i % 4);
         {e.hi, e.lo} = smul(ta[i % 4], tb[i % 4]);
         sb_q.push_back(e);
      end
      req = 4'hF;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_ack(40, ack_c[i]);
      end
      req = 4'd0;
      for (int i = 1; i < 5; i++) begin
         tb_check("rr_spacing", 64'(ack_c[i] - ack_c[i-1]), 64'd10);
      end
      repeat (3) @(negedge clock);
      tb_check("sb_drained", 64'(sb_q.size()), 64'd0);
      tb_check("final_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
